// File: rtl/misr_pkg.sv
// Shared types and constants for the c5315 BIST response compactor:
// FSM state encoding, default MISR polynomial/seed and the XOR fold function.
package misr_pkg;

  localparam int MISR_WIDTH = 123;
  localparam int MISR_SIG_W = 32;
  localparam int MISR_CNT_W = 16;

  localparam logic [MISR_SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [MISR_SIG_W-1:0] DEF_SEED = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } misr_state_e;

  // Bit j of the response lands on signature bit (j mod SIG_W).
  function automatic logic [MISR_SIG_W-1:0] fold_resp(input logic [MISR_WIDTH-1:0] data);
    logic [MISR_SIG_W-1:0] acc;
    acc = {MISR_SIG_W{1'b0}};
    for (int j = 0; j < MISR_WIDTH; j++) begin
      acc[j % MISR_SIG_W] = acc[j % MISR_SIG_W] ^ data[j];
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr_fold.sv
// Combinational WIDTH->SIG_W XOR space compactor feeding the MISR.
module misr_fold
  import misr_pkg::*;
#(
  parameter int WIDTH = MISR_WIDTH,
  parameter int SIG_W = MISR_SIG_W
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [SIG_W-1:0] fold_o
);

  generate
    if (WIDTH == MISR_WIDTH && SIG_W == MISR_SIG_W) begin : g_pkg_fold
      assign fold_o = fold_resp(data_i);
    end else begin : g_generic_fold
      // Same folding rule for non-default geometries.
      always_comb begin
        fold_o = {SIG_W{1'b0}};
        for (int j = 0; j < WIDTH; j++) begin
          fold_o[j % SIG_W] = fold_o[j % SIG_W] ^ data_i[j];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/misr_response_compactor.sv
// MISR output-response analyzer: compacts one response per accepted beat and
// compares against a golden signature. Optional X-masking via MISR_XMASK_EN.
module misr_response_compactor
  import misr_pkg::*;
#(
  parameter int                 WIDTH = MISR_WIDTH,
  parameter int                 SIG_W = MISR_SIG_W,
  parameter logic [SIG_W-1:0]   POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0]   SEED  = DEF_SEED,
  parameter int                 CNT_W = MISR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] resp_data,
`ifdef MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_xmask,
`endif
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  misr_state_e      state_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] target_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [WIDTH-1:0] data_masked_s;
  logic [SIG_W-1:0] fold_s;
  logic             beat_s;
  logic             last_s;

`ifdef MISR_XMASK_EN
  assign data_masked_s = resp_data & ~resp_xmask;
`else
  assign data_masked_s = resp_data;
`endif

  misr_fold #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W)
  ) u_fold (
    .data_i (data_masked_s),
    .fold_o (fold_s)
  );

  assign resp_ready = (state_q == COMPACT);
  assign beat_s     = resp_valid && (state_q == COMPACT);

  // Next MISR value, saturating count, last-beat detect and clamped target.
  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ fold_s;
    if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    last_s = beat_s &&
             (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, target_q});
    if (num_pat == {CNT_W{1'b0}}) begin
      target_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      target_d = num_pat;
    end
  end

  // Run-control FSM with MISR, counter and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      cnt_q    <= {CNT_W{1'b0}};
      target_q <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= COMPACT;
            sig_q    <= SEED;
            cnt_q    <= {CNT_W{1'b0}};
            target_q <= target_d;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        COMPACT: begin
          if (beat_s) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (last_s) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden_sig);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_misr_response_compactor.sv
// Randomized self-checking bench for misr_response_compactor against a
// behavioural MISR model; two instances (SEED 0 and SEED 32'h80000000).
module tb_misr_response_compactor;

  localparam logic [31:0] POLY_C = 32'h04C11DB7;
  localparam logic [31:0] SEED2  = 32'h80000000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [15:0]  num_pat;
  logic         resp_valid;
  logic [122:0] resp_data;
  logic [122:0] xmask_v;
  logic [31:0]  golden_sig;
  logic         resp_ready, busy, done, pass;
  logic [31:0]  signature;
  logic [15:0]  pat_count;
  logic         resp_ready_b, busy_b, done_b, pass_b;
  logic [31:0]  signature_b;
  logic [15:0]  pat_count_b;

  int n_checks;
  int n_fail;

  logic [31:0] m_sig, m_sig2;
  logic [15:0] m_cnt, m_target;
  logic        m_busy, m_done, m_pass, m_pass2;

  misr_response_compactor u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pat    (num_pat),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef MISR_XMASK_EN
    .resp_xmask (xmask_v),
`endif
    .golden_sig (golden_sig),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .pat_count  (pat_count)
  );

  misr_response_compactor #(.SEED(SEED2)) u_dut_seed (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pat    (num_pat),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready_b),
    .resp_data  (resp_data),
`ifdef MISR_XMASK_EN
    .resp_xmask (xmask_v),
`endif
    .golden_sig (golden_sig),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .signature  (signature_b),
    .pat_count  (pat_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fold(input logic [122:0] d);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < 123; i++) f[i % 32] ^= d[i];
    return f;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [122:0] d);
    logic [122:0] eff;
`ifdef MISR_XMASK_EN
    eff = d & ~xmask_v;
`else
    eff = d;
`endif
    return {s[30:0], 1'b0} ^ (s[31] ? POLY_C : 32'h0) ^ ref_fold(eff);
  endfunction

  function automatic logic [122:0] rnd_data();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[122:0];
  endfunction

  task automatic model_reset();
    m_sig = 32'h0; m_sig2 = SEED2; m_cnt = 16'h0; m_target = 16'h0;
    m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_pass2 = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_sig"},   {32'h0, signature},   {32'h0, m_sig});
    check_eq({tag, "_sig_b"}, {32'h0, signature_b}, {32'h0, m_sig2});
    check_eq({tag, "_cnt"},   {48'h0, pat_count},   {48'h0, m_cnt});
    check_eq({tag, "_cnt_b"}, {48'h0, pat_count_b}, {48'h0, m_cnt});
    check_eq({tag, "_busy"},  {63'h0, busy},  {63'h0, m_busy});
    check_eq({tag, "_done"},  {63'h0, done},  {63'h0, m_done});
    check_eq({tag, "_done_b"},{63'h0, done_b},{63'h0, m_done});
    check_eq({tag, "_pass"},  {63'h0, pass},  {63'h0, m_pass});
    check_eq({tag, "_pass_b"},{63'h0, pass_b},{63'h0, m_pass2});
  endtask

  // One clock: drive, check ready before the edge, advance model, check after.
  task automatic tick(input logic v, input logic [122:0] d, input logic st,
                      input logic [15:0] n, input logic [31:0] g);
    resp_valid = v; resp_data = d; start = st; num_pat = n; golden_sig = g;
    #1;
    check_eq("ready",   {63'h0, resp_ready},   {63'h0, m_busy});
    check_eq("ready_b", {63'h0, resp_ready_b}, {63'h0, m_busy});
    if (!m_busy && st) begin
      m_sig = 32'h0; m_sig2 = SEED2; m_cnt = 16'h0;
      m_target = (n == 16'h0) ? 16'h1 : n;
      m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_pass2 = 1'b0;
    end else if (m_busy && v) begin
      m_sig  = ref_step(m_sig, d);
      m_sig2 = ref_step(m_sig2, d);
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (m_cnt == m_target) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_pass = (m_sig == g); m_pass2 = (m_sig2 == g);
      end
    end
    @(posedge clk);
    #1;
    check_outputs("tick");
    resp_valid = 1'b0; start = 1'b0;
  endtask

  task automatic rand_run();
    logic [15:0]  n;
    logic [122:0] d;
    logic [31:0]  g;
    logic         v;
    int           cyc;
    n = 16'($urandom_range(1, 8));
    tick(1'b0, 123'h0, 1'b1, n, 32'h0);
    cyc = 0;
    while (m_busy && cyc < 300) begin
      v = ($urandom_range(0, 9) < 7);
      d = rnd_data();
      g = ($urandom_range(0, 1) == 1) ? ref_step(m_sig, d) : $urandom;
      tick(v, d, ($urandom_range(0, 19) == 0), 16'($urandom_range(0, 9)), g);
      cyc++;
    end
    check_eq("run_done", {63'h0, done}, 64'h1);
  endtask

  logic [6:0]   hs_pat;
  logic [122:0] d_fold;

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; num_pat = 16'h0; resp_valid = 1'b0;
    resp_data = 123'h0; golden_sig = 32'h0; xmask_v = 123'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset");

    // Single beat of 1 with matching and mismatching golden.
    tick(1'b0, 123'h0, 1'b1, 16'd1, 32'h0);
    tick(1'b1, 123'h1, 1'b0, 16'd0, 32'h1);
    check_eq("t2_sig",  {32'h0, signature}, 64'h1);
    check_eq("t2_pass", {63'h0, pass}, 64'h1);
    tick(1'b0, 123'h0, 1'b1, 16'd1, 32'h0);
    tick(1'b1, 123'h1, 1'b0, 16'd0, 32'h2);
    check_eq("t2_fail_pass", {63'h0, pass}, 64'h0);
    check_eq("t2_fail_done", {63'h0, done}, 64'h1);
    tick(1'b0, 123'h0, 1'b0, 16'd0, 32'h0);

    // Bits 32 and 96 cancel in the fold.
    d_fold = 123'h0;
    d_fold[32] = 1'b1;
    d_fold[96] = 1'b1;
    tick(1'b0, 123'h0, 1'b1, 16'd1, 32'h0);
    tick(1'b1, d_fold, 1'b0, 16'd0, 32'h0);
    check_eq("t3_sig", {32'h0, signature}, 64'h0);

    // Feedback from a set MSB seed.
    tick(1'b0, 123'h0, 1'b1, 16'd1, 32'h0);
    tick(1'b1, 123'h0, 1'b0, 16'd0, 32'h0);
    check_eq("t4_sig_b", {32'h0, signature_b}, 64'h04C11DB7);

    // Handshake stalls; start mid-run must be ignored.
    hs_pat = 7'b1011001;
    tick(1'b0, 123'h0, 1'b1, 16'd4, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick(hs_pat[i], rnd_data(), (i == 2), 16'd9, 32'h0);
      if (i == 5) check_eq("t5_not_done", {63'h0, done}, 64'h0);
    end
    check_eq("t5_cnt",  {48'h0, pat_count}, 64'h4);
    check_eq("t5_done", {63'h0, done}, 64'h1);

    // num_pat of zero behaves as one.
    tick(1'b0, 123'h0, 1'b1, 16'd0, 32'h0);
    tick(1'b1, rnd_data(), 1'b0, 16'd0, 32'h0);
    check_eq("np0_done", {63'h0, done}, 64'h1);

    // Start and valid together in DONE: start wins.
    tick(1'b1, rnd_data(), 1'b1, 16'd2, 32'h0);
    check_eq("sw_cnt", {48'h0, pat_count}, 64'h0);
    tick(1'b1, rnd_data(), 1'b0, 16'd0, 32'h0);

    // Asynchronous reset mid-run.
    tick(1'b1, rnd_data(), 1'b0, 16'd0, 32'h0);
    tick(1'b0, 123'h0, 1'b1, 16'd5, 32'h0);
    tick(1'b1, rnd_data(), 1'b0, 16'd0, 32'h0);
    tick(1'b1, rnd_data(), 1'b0, 16'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t1_sig",   {32'h0, signature}, 64'h0);
    check_eq("t1_cnt",   {48'h0, pat_count}, 64'h0);
    check_eq("t1_done",  {63'h0, done}, 64'h0);
    check_eq("t1_ready", {63'h0, resp_ready}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("t1_after");

`ifdef MISR_XMASK_EN
    xmask_v = 123'h1;
    tick(1'b0, 123'h0, 1'b1, 16'd1, 32'h0);
    tick(1'b1, 123'h1, 1'b0, 16'd0, 32'h0);
    check_eq("t6_masked", {32'h0, signature}, 64'h0);
    xmask_v = 123'h0;
    tick(1'b0, 123'h0, 1'b1, 16'd1, 32'h0);
    tick(1'b1, 123'h1, 1'b0, 16'd0, 32'h0);
    check_eq("t6_unmasked", {32'h0, signature}, 64'h1);
    xmask_v = rnd_data();
    for (int r = 0; r < 5; r++) rand_run();
    xmask_v = 123'h0;
`endif

    for (int r = 0; r < 25; r++) rand_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
